// File: rtl/csr_unit_v2.sv
// Machine-mode CSR file for the OTTER core: status/enable/pending, trap vector,
// mepc/mcause bookkeeping on trap entry and mret, and 64-bit cycle/instret counters.
module csr_unit_v2 #(
  parameter int unsigned NUM_IRQ      = 4,
  parameter int unsigned HAS_COUNTERS = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [1:0]         CSR_OP,
  input  logic [11:0]        ADDR,
  input  logic [31:0]        WD,
  input  logic [31:0]        PC,
  input  logic               INSTR_RETIRE,
  input  logic               MRET_EXEC,
  input  logic               INT_TAKEN,
  input  logic [NUM_IRQ-1:0] IRQ,
  output logic [31:0]        RD,
  output logic               ILLEGAL_ADDR,
  output logic               INT_PENDING,
  output logic [31:0]        TRAP_VEC,
  output logic [31:0]        CSR_MEPC,
  output logic               CSR_MSTATUS_MIE
);

  localparam int unsigned IDX_W = 5;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;

  logic               mstatus_mie;
  logic               mstatus_mpie;
  logic [NUM_IRQ-1:0] mie_q;
  logic [NUM_IRQ-1:0] mip_q;
  logic [31:0]        mtvec_q;
  logic [31:0]        mepc_q;
  logic [31:0]        mcause_q;
  logic [63:0]        mcycle_q;
  logic [63:0]        minstret_q;

  logic               impl;
  logic               wr;
  logic [31:0]        wdata;
  logic [NUM_IRQ-1:0] pend;
  logic [IDX_W-1:0]   irq_idx;
  logic [31:0]        cause_code;
  logic [31:0]        vec_base;

  // Read mux; RD is the pre-write value and also the old operand for RS/RC
  always_comb begin
    RD   = 32'd0;
    impl = 1'b1;
    case (ADDR)
      A_MSTATUS: RD = {24'd0, mstatus_mpie, 3'b000, mstatus_mie, 3'b000};
      A_MIE:     RD = 32'(mie_q);
      A_MTVEC:   RD = mtvec_q;
      A_MEPC:    RD = mepc_q;
      A_MCAUSE:  RD = mcause_q;
      A_MIP:     RD = 32'(mip_q);
      A_MCYCLE: begin
        if (HAS_COUNTERS != 0) RD = mcycle_q[31:0];
        else                   impl = 1'b0;
      end
      A_MCYCLEH: begin
        if (HAS_COUNTERS != 0) RD = mcycle_q[63:32];
        else                   impl = 1'b0;
      end
      A_MINSTRET: begin
        if (HAS_COUNTERS != 0) RD = minstret_q[31:0];
        else                   impl = 1'b0;
      end
      A_MINSTRETH: begin
        if (HAS_COUNTERS != 0) RD = minstret_q[63:32];
        else                   impl = 1'b0;
      end
      default: impl = 1'b0;
    endcase
  end

  always_comb begin
    wdata = WD;
    case (CSR_OP)
      2'b10:   wdata = RD | WD;
      2'b11:   wdata = RD & ~WD;
      default: wdata = WD;
    endcase
  end

  assign wr           = (CSR_OP != 2'b00) && impl;
  assign ILLEGAL_ADDR = (CSR_OP != 2'b00) && !impl;

  // Lowest-numbered enabled pending line wins
  always_comb begin
    pend    = mip_q & mie_q;
    irq_idx = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (pend[i]) irq_idx = IDX_W'(i);
    end
  end

  assign cause_code  = 32'd16 + 32'(irq_idx);
  assign vec_base    = {mtvec_q[31:2], 2'b00};
  assign TRAP_VEC    = mtvec_q[0] ? (vec_base + (cause_code << 2)) : vec_base;
  assign INT_PENDING = mstatus_mie && (|pend);

  assign CSR_MEPC        = mepc_q;
  assign CSR_MSTATUS_MIE = mstatus_mie;

  // Trap entry outranks mret, which outranks a CSR write, field by field
  always_ff @(posedge CLK) begin
    if (RST) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mip_q        <= '0;
      mtvec_q      <= 32'd0;
      mepc_q       <= 32'd0;
      mcause_q     <= 32'd0;
      mcycle_q     <= 64'd0;
      minstret_q   <= 64'd0;
    end else begin
      mip_q <= IRQ;

      if (INT_TAKEN) begin
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (MRET_EXEC) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (wr && ADDR == A_MSTATUS) begin
        mstatus_mie  <= wdata[3];
        mstatus_mpie <= wdata[7];
      end

      if (INT_TAKEN) begin
        mepc_q   <= PC & ~32'd3;
        mcause_q <= 32'h8000_0000 | cause_code;
      end else begin
        if (wr && ADDR == A_MEPC)   mepc_q   <= wdata & ~32'd3;
        if (wr && ADDR == A_MCAUSE) mcause_q <= wdata;
      end

      if (wr && ADDR == A_MIE)   mie_q   <= wdata[NUM_IRQ-1:0];
      if (wr && ADDR == A_MTVEC) mtvec_q <= wdata & 32'hFFFF_FFFD;

      if (HAS_COUNTERS != 0) begin
        if (wr && ADDR == A_MCYCLE)       mcycle_q[31:0]  <= wdata;
        else if (wr && ADDR == A_MCYCLEH) mcycle_q[63:32] <= wdata;
        else                              mcycle_q        <= mcycle_q + 64'd1;

        if (wr && ADDR == A_MINSTRET)       minstret_q[31:0]  <= wdata;
        else if (wr && ADDR == A_MINSTRETH) minstret_q[63:32] <= wdata;
        else if (INSTR_RETIRE)              minstret_q        <= minstret_q + 64'd1;
      end
    end
  end

endmodule
